// File: rtl/i_cache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package i_cache_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int INDEX_W_DEF  = 6;
    localparam int OFFSET_W_DEF = 2;

    // Controller states: lookup, line refill from backing memory, miss response.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        RESPOND = 2'd2
    } state_t;

endpackage

// File: rtl/i_cache_data_ram.sv
// Instruction data store: synchronous single-port RAM, one word per entry.
// Read data appears the cycle after the address is presented.
module i_cache_data_ram
    import i_cache_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = INDEX_W_DEF + OFFSET_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    // Registered read of the addressed word; write when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/i_cache_dm.sv
// Direct-mapped instruction cache with whole-line refill from a word-wide
// backing memory. Tags and valid bits live here; words live in the data RAM.
//
// Backing-memory handshake: mem_req/mem_addr are raised together and held
// unchanged until a cycle in which mem_req=1 and mem_ack=1; that cycle
// transfers mem_data. mem_ack while mem_req=0 carries no meaning and is ignored.
module i_cache_dm
    import i_cache_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int INDEX_W  = INDEX_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_dest,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic [1:0]        state_dbg
);

    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES  = 2**INDEX_W;
    localparam int RAM_AW = INDEX_W + OFFSET_W;

    state_t state, state_nxt;

    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_mem [LINES];
    logic                flush_pend;

    // Address of the most recently accepted fetch; during a refill it is the miss address.
    logic [ADDR_W-1:0]   req_addr;
    logic [OFFSET_W-1:0] fill_cnt;
    logic [DATA_W-1:0]   cap_word;
    logic                hit_q;
    logic [DATA_W-1:0]   out_hold;
    logic [ADDR_W-1:0]   pc_hold;

    logic [INDEX_W-1:0]  look_index;
    logic [TAG_W-1:0]    look_tag;
    logic [INDEX_W-1:0]  fill_index;
    logic                lookup_hit;
    logic                accept;
    logic                hit_acc;
    logic                miss_acc;
    logic                ack_ok;
    logic                last_ack;

    logic                ram_we;
    logic [RAM_AW-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_rdata;

    assign look_index = rd_dest[OFFSET_W +: INDEX_W];
    assign look_tag   = rd_dest[ADDR_W-1 -: TAG_W];
    assign fill_index = req_addr[OFFSET_W +: INDEX_W];
    assign lookup_hit = valid[look_index] && (tag_mem[look_index] == look_tag);

    // A flush arriving with the fetch wins, so the fetch takes the miss path.
    assign accept     = (state == IDLE) && rd_en;
    assign hit_acc    = accept && !flush && lookup_hit;
    assign miss_acc   = accept && !hit_acc;
    assign ack_ok     = (state == REFILL) && mem_req && mem_ack;
    assign last_ack   = ack_ok && (fill_cnt == {OFFSET_W{1'b1}});

    // Refill writes own the RAM port; otherwise it reads the word being looked up.
    assign ram_we   = ack_ok;
    assign ram_addr = (state == REFILL) ? {fill_index, fill_cnt} : rd_dest[RAM_AW-1:0];

    i_cache_data_ram #(
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (mem_data),
        .rdata (ram_rdata)
    );

    // Hit words come straight from the RAM read port; miss words from the capture register.
    assign rd_valid  = hit_q || (state == RESPOND);
    assign rd_out    = hit_q ? ram_rdata : ((state == RESPOND) ? cap_word : out_hold);
    assign pc_out    = rd_valid ? req_addr : pc_hold;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss_acc) state_nxt = REFILL;
            REFILL:  if (last_ack) state_nxt = RESPOND;
            RESPOND: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fetch bookkeeping: hit pulse, fetch address, and last-delivered output values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q    <= 1'b0;
            req_addr <= '0;
            out_hold <= '0;
            pc_hold  <= '0;
        end else begin
            hit_q <= hit_acc;
            if (accept) begin
                req_addr <= rd_dest;
            end
            if (rd_valid) begin
                out_hold <= rd_out;
                pc_hold  <= pc_out;
            end
        end
    end

    // Refill sequencer: walks the line from offset 0 upward, one request outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            fill_cnt <= '0;
            cap_word <= '0;
        end else if (miss_acc) begin
            mem_req  <= 1'b1;
            mem_addr <= {rd_dest[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            fill_cnt <= '0;
        end else if (ack_ok) begin
            if (fill_cnt == req_addr[OFFSET_W-1:0]) begin
                cap_word <= mem_data;
            end
            if (last_ack) begin
                mem_req <= 1'b0;
            end else begin
                fill_cnt <= fill_cnt + 1'b1;
                mem_addr <= {req_addr[ADDR_W-1:OFFSET_W], fill_cnt + 1'b1};
            end
        end
    end

    // Valid bits and deferred flush; a flush seen while busy clears everything,
    // including the fresh line, as the response retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= '0;
            flush_pend <= 1'b0;
        end else begin
            if ((state != IDLE) && flush) begin
                flush_pend <= 1'b1;
            end
            if ((state == IDLE) && flush) begin
                valid <= '0;
            end else if ((state == RESPOND) && (flush_pend || flush)) begin
                valid      <= '0;
                flush_pend <= 1'b0;
            end else if (last_ack) begin
                valid[fill_index] <= 1'b1;
            end
        end
    end

    // Tag store; only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (last_ack) begin
            tag_mem[fill_index] <= req_addr[ADDR_W-1 -: TAG_W];
        end
    end

endmodule

// File: tb/tb_i_cache_dm.sv
// Self-checking bench for i_cache_dm: directed scenarios plus randomized fetches
// against a line-level model of a 64-line, 4-word direct-mapped cache.
module tb_i_cache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [15:0] rd_dest;
  logic        flush;
  logic [15:0] rd_out;
  logic [15:0] pc_out;
  logic        rd_valid;
  logic        busy;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Backing-memory behaviour controls and transfer log.
  int          ack_delay = 1;
  bit          rand_delay = 0;
  bit          stray_en = 0;
  logic [15:0] mem_log[$];

  // Reference model: which line (address >> 2) each index holds, -1 when empty.
  int model_line[64];

  i_cache_dm dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_dest   (rd_dest),
    .flush     (flush),
    .rd_out    (rd_out),
    .pc_out    (pc_out),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    w = 16'hA000 + a;
    return w;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) model_line[i] = -1;
  endfunction

  // Backing memory: answers each request after a delay, logs transferred addresses,
  // checks request stability while waiting, and can inject acks with no request.
  initial begin : mem_responder
    int          wait_cnt;
    int          this_delay;
    bit          waiting;
    logic [15:0] held_addr;
    wait_cnt = 0;
    this_delay = 0;
    waiting = 0;
    held_addr = '0;
    mem_ack = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst) begin
        wait_cnt = 0;
        waiting = 0;
      end else if (mem_req) begin
        if (waiting) begin
          checks++;
          if (mem_addr !== held_addr) begin
            errors++;
            $display("FAIL mem_addr_stable: got %h required %h", mem_addr, held_addr);
          end
        end else begin
          this_delay = rand_delay ? int'($urandom_range(0, 2)) : ack_delay;
        end
        if (wait_cnt < this_delay) begin
          wait_cnt++;
          waiting = 1;
          held_addr = mem_addr;
        end else begin
          mem_ack = 1'b1;
          mem_data = mem_word(mem_addr);
          mem_log.push_back(mem_addr);
          wait_cnt = 0;
          waiting = 0;
        end
      end else begin
        waiting = 0;
        if (stray_en && $urandom_range(0, 3) == 0) begin
          mem_ack = 1'b1;
          mem_data = 16'hDEAD;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s idle_wait: busy still 1 after 100 cycles, required 0", name);
    end
  endtask

  // One fetch: predicts hit/miss from the model, optionally pulses flush with the
  // request or at a given cycle while busy, then checks latency, data and refill order.
  task automatic do_fetch(input logic [15:0] a, input bit with_flush, input int flush_at,
                          input string name);
    int          cyc;
    bit          exp_hit;
    bit          obs_hit;
    bit          flushed_mid;
    logic [15:0] base;
    logic [15:0] ea;
    wait_idle(name);
    exp_hit = !with_flush && (model_line[a[7:2]] == int'(a[15:2]));
    mem_log.delete();
    flushed_mid = 0;
    rd_en = 1'b1;
    rd_dest = a;
    flush = with_flush;
    @(negedge clk);
    rd_en = 1'b0;
    flush = 1'b0;
    cyc = 0;
    while (rd_valid !== 1'b1 && cyc < 100) begin
      if (cyc == flush_at) begin
        flush = 1'b1;
        flushed_mid = 1;
      end
      @(negedge clk);
      flush = 1'b0;
      cyc++;
    end
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s response_timeout: rd_valid %b after %0d cycles, required 1", name, rd_valid, cyc);
      return;
    end
    obs_hit = (cyc == 0) && (mem_log.size() == 0);
    checks++;
    if (obs_hit !== exp_hit) begin
      errors++;
      $display("FAIL %s hit: got %0d (latency %0d, %0d mem words) required %0d", name, obs_hit, cyc, mem_log.size(), exp_hit);
    end
    checks++;
    if (rd_out !== mem_word(a)) begin
      errors++;
      $display("FAIL %s rd_out: got %h required %h", name, rd_out, mem_word(a));
    end
    checks++;
    if (pc_out !== a) begin
      errors++;
      $display("FAIL %s pc_out: got %h required %h", name, pc_out, a);
    end
    if (!exp_hit) begin
      base = {a[15:2], 2'b00};
      checks++;
      if (mem_log.size() != 4) begin
        errors++;
        $display("FAIL %s refill_len: got %0d words required 4", name, mem_log.size());
      end
      for (int i = 0; i < 4 && i < mem_log.size(); i++) begin
        ea = base + 16'(i);
        checks++;
        if (mem_log[i] !== ea) begin
          errors++;
          $display("FAIL %s refill_addr[%0d]: got %h required %h", name, i, mem_log[i], ea);
        end
      end
    end
    if (with_flush) model_clear();
    model_line[a[7:2]] = int'(a[15:2]);
    if (flushed_mid) model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_en = 1'b0;
    rd_dest = '0;
    flush = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_valid, busy, mem_req} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got rd_valid/busy/mem_req %b required 000", {rd_valid, busy, mem_req});
    end
    checks++;
    if ({rd_out, pc_out, mem_addr} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: got rd_out %h pc_out %h mem_addr %h required all 0", rd_out, pc_out, mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_valid, busy, mem_req} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_ctrl: got %b required 000", {rd_valid, busy, mem_req});
    end
  endtask

  task automatic test_first_miss();
    ack_delay = 1;
    do_fetch(16'h0010, 0, -1, "first_miss");
  endtask

  task automatic test_back_to_back();
    logic [15:0] ea;
    wait_idle("b2b");
    mem_log.delete();
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      rd_dest = 16'h0011 + 16'(i);
      @(negedge clk);
      ea = 16'hA011 + 16'(i);
      checks++;
      if (rd_valid !== 1'b1 || rd_out !== ea) begin
        errors++;
        $display("FAIL b2b_word[%0d]: got valid %b data %h required 1 %h", i, rd_valid, rd_out, ea);
      end
      ea = 16'h0011 + 16'(i);
      checks++;
      if (pc_out !== ea || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL b2b_pc[%0d]: got pc %h mem_req %b required %h 0", i, pc_out, mem_req, ea);
      end
    end
    rd_en = 1'b0;
    checks++;
    if (mem_log.size() != 0) begin
      errors++;
      $display("FAIL b2b_no_refill: got %0d mem words required 0", mem_log.size());
    end
  endtask

  task automatic test_hold();
    do_fetch(16'h0123, 0, -1, "hold_fetch");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || rd_out !== mem_word(16'h0123) || pc_out !== 16'h0123) begin
        errors++;
        $display("FAIL hold[%0d]: got valid %b rd_out %h pc_out %h required 0 %h 0123", i, rd_valid, rd_out, pc_out, mem_word(16'h0123));
      end
    end
  endtask

  task automatic test_conflict();
    do_fetch(16'h0010, 0, -1, "conflict_a");
    do_fetch(16'h0110, 0, -1, "conflict_b");
    do_fetch(16'h0010, 0, -1, "conflict_a_again");
  endtask

  task automatic test_flush_refill();
    do_fetch(16'h0020, 0, 1, "flush_in_refill");
    do_fetch(16'h0020, 0, -1, "after_refill_flush");
  endtask

  task automatic test_flush_idle();
    do_fetch(16'h0011, 0, -1, "pre_flush");
    wait_idle("flush_idle");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    do_fetch(16'h0012, 0, -1, "after_idle_flush");
    do_fetch(16'h0013, 1, -1, "flush_with_read");
    do_fetch(16'h0011, 0, -1, "refilled_after_flush_read");
  endtask

  task automatic test_reset_mid_refill();
    int cyc;
    do_fetch(16'h0031, 0, -1, "pre_reset");
    do_fetch(16'h0130, 0, -1, "reset_target_miss_prep");
    wait_idle("reset_mid");
    mem_log.delete();
    ack_delay = 1;
    rd_en = 1'b1;
    rd_dest = 16'h0030;
    @(negedge clk);
    rd_en = 1'b0;
    cyc = 0;
    while (mem_log.size() < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (mem_log.size() < 2) begin
      errors++;
      $display("FAIL reset_mid_progress: got %0d mem words required 2", mem_log.size());
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({rd_valid, busy, mem_req} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_ctrl: got rd_valid/busy/mem_req %b required 000", {rd_valid, busy, mem_req});
    end
    checks++;
    if ({rd_out, pc_out, mem_addr} !== 48'h0) begin
      errors++;
      $display("FAIL reset_mid_data: got rd_out %h pc_out %h mem_addr %h required all 0", rd_out, pc_out, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    do_fetch(16'h0030, 0, -1, "after_reset_refill");
  endtask

  task automatic test_top_line();
    do_fetch(16'hFFFE, 0, -1, "top_line_miss");
    do_fetch(16'hFFFC, 0, -1, "top_line_hit_lo");
    do_fetch(16'hFFFF, 0, -1, "top_line_hit_hi");
  endtask

  task automatic test_random();
    logic [15:0] a;
    bit          wf;
    int          fa;
    rand_delay = 1;
    stray_en = 1;
    for (int n = 0; n < 60; n++) begin
      a = 16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) a = 16'hFFF0 | 16'($urandom_range(0, 15));
      wf = ($urandom_range(0, 7) == 0);
      fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_fetch(a, wf, fa, $sformatf("random[%0d]", n));
    end
    rand_delay = 0;
    stray_en = 0;
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_back_to_back();
    test_hold();
    test_conflict();
    test_flush_refill();
    test_flush_idle();
    test_reset_mid_refill();
    test_top_line();
    test_random();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
